branch1_reader: RTL

Streaming reader for the branch-1 metric RAM inside the SISO decoder. After the branch-1 calculation path has filled the RAM, this block sequences read addresses in forward order (alpha recursion) or reverse order (beta recursion). It absorbs the RAM's one-cycle read latency and delivers metrics on a valid/ready stream with full backpressure. It drives the RAM read port directly and feeds the forward/backward state-metric units.

---
 rtl/branch1_pkg.sv | 27 ++
 rtl/branch1_read_fifo.sv | 62 ++++++
 rtl/branch1_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/branch1_pkg.sv
// Shared types and sizing helpers for the branch-1 metric RAM reader.
package branch1_pkg;

  localparam int FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/branch1_read_fifo.sv
// Three-entry FIFO holding {metric, source address, last flag} behind the RAM read.
module branch1_read_fifo
  import branch1_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AW     = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              last_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] data_o,
  output logic [AW-1:0]     addr_o,
  output logic              last_o,
  output logic [1:0]        count_o,
  output logic              valid_o
);

  logic [DWIDTH-1:0] data_q [FIFO_DEPTH];
  logic [AW-1:0]     addr_q [FIFO_DEPTH];
  logic              last_q [FIFO_DEPTH];
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;

  // Entries are cleared on reset so the head reads back as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= data_i;
        addr_q[wr_ptr_q] <= addr_i;
        last_q[wr_ptr_q] <= last_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = data_q[rd_ptr_q];
  assign addr_o  = addr_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/branch1_reader.sv
// Streams the branch-1 metric RAM in ascending or descending order with backpressure.
// Define BRANCH1_READER_BASE_EN to add the i_base port and wrap-around addressing.
//
// state    | meaning
// ST_IDLE  | waiting for a valid start request
// ST_RUN   | issuing one RAM read per cycle while buffer space allows
// ST_DRAIN | all reads issued, waiting for the last item to be accepted
module branch1_reader
  import branch1_pkg::*;
#(
  parameter int  DWIDTH      = 16,
  parameter int  BRANCH_SIZE = 3072,
  localparam int AW          = addr_w(BRANCH_SIZE),
  localparam int LW          = len_w(BRANCH_SIZE)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [LW-1:0]     i_len,
`ifdef BRANCH1_READER_BASE_EN
  input  logic [AW-1:0]     i_base,
`endif
  output logic              o_busy,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [DWIDTH-1:0] i_rd_data,
  output logic [DWIDTH-1:0] o_data,
  output logic [AW-1:0]     o_addr,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
);

  localparam int SW = LW + 1;

  state_e        state_q;
  logic          dir_q;
  logic [LW-1:0] rem_q;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_vld_q, rd_last_q;
  logic          dat_vld_q, dat_last_q;
  logic [AW-1:0] dat_addr_q;
  logic          done_q;

  logic [AW-1:0] base_w, first_addr_d;
  logic [SW-1:0] bwd_sum;
  logic          start_ok, pop, can_issue, head_valid, head_last;
  logic [1:0]    fifo_cnt;
  logic [2:0]    live;

`ifdef BRANCH1_READER_BASE_EN
  assign base_w = i_base;
`else
  assign base_w = '0;
`endif

  always_comb begin
    start_ok = i_start && (i_len != '0) && (i_len <= LW'(BRANCH_SIZE));
    bwd_sum  = SW'(base_w) + SW'(i_len) - SW'(1);
    if (bwd_sum >= SW'(BRANCH_SIZE)) begin
      bwd_sum = bwd_sum - SW'(BRANCH_SIZE);
    end
    first_addr_d = (i_dir == DIR_BWD) ? AW'(bwd_sum) : base_w;

    if (dir_q == DIR_FWD) begin
      rd_addr_d = (rd_addr_q == AW'(BRANCH_SIZE - 1)) ? '0 : rd_addr_q + AW'(1);
    end else begin
      rd_addr_d = (rd_addr_q == '0) ? AW'(BRANCH_SIZE - 1) : rd_addr_q - AW'(1);
    end

    // Items alive after this edge: buffered, in the RAM pipeline, minus the one leaving now.
    pop       = head_valid & i_ready;
    live      = 3'(fifo_cnt) + 3'(dat_vld_q) + 3'(rd_vld_q) - 3'(pop);
    can_issue = (live < 3'(FIFO_DEPTH));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_FWD;
      rem_q      <= '0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      dat_vld_q  <= 1'b0;
      dat_addr_q <= '0;
      dat_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      dat_vld_q  <= rd_vld_q;
      dat_addr_q <= rd_addr_q;
      dat_last_q <= rd_last_q;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q   <= (i_len == LW'(1)) ? ST_DRAIN : ST_RUN;
            dir_q     <= i_dir;
            rd_addr_q <= first_addr_d;
            rd_vld_q  <= 1'b1;
            rd_last_q <= (i_len == LW'(1));
            rem_q     <= i_len - LW'(1);
          end
        end
        ST_RUN: begin
          if (can_issue) begin
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= 1'b1;
            rd_last_q <= (rem_q == LW'(1));
            rem_q     <= rem_q - LW'(1);
            if (rem_q == LW'(1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  branch1_read_fifo #(
    .DWIDTH (DWIDTH),
    .AW     (AW)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (dat_vld_q),
    .data_i  (i_rd_data),
    .addr_i  (dat_addr_q),
    .last_i  (dat_last_q),
    .pop_i   (pop),
    .data_o  (o_data),
    .addr_o  (o_addr),
    .last_o  (head_last),
    .count_o (fifo_cnt),
    .valid_o (head_valid)
  );

  assign o_busy    = (state_q != ST_IDLE);
  assign o_rd_addr = rd_addr_q;
  assign o_valid   = head_valid;
  assign o_last    = head_valid & head_last;
  assign o_done    = done_q;

endmodule
